// File: rtl/and_gate_test_sequencer.sv
// rtl/and_gate_test_sequencer.sv - self-test sequencer for the shared two-input AND gate unit
//
// Purpose:
//   On a start pulse, walks the gate inputs through {A,B} = 00, 01, 10, 11.
//   Each vector is driven for HOLD_CYCLES cycles and then sampled for one cycle.
//   Every sample of C is compared with A&B. Mismatches are counted, and the
//   first failing vector is captured. A start/busy/done handshake reports the
//   result. While a test runs, this block owns the gate inputs.
//
// Parameters:
//   HOLD_CYCLES  settle cycles per vector before C is sampled (1..255)
//   CNT_W        hold counter width, 2**CNT_W > HOLD_CYCLES
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   start        begin a test (accepted in IDLE or DONE only)
//   abort        cancel a running test (only while busy)
//   C_in         output C of the gate under test
//   A_out, B_out gate inputs A and B
//   busy         test in progress (DRIVE or SAMPLE)
//   done         test finished, held until next start or reset
//   pass         done with zero mismatches
//   err_count    number of mismatching vectors (0..4)
//   fail_vec     first mismatching vector {A,B}, valid when fail_valid
//   fail_valid   sticky flag for the first mismatch of a run

module and_gate_test_sequencer #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       C_in,
  output logic       A_out,
  output logic       B_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [1:0] fail_vec,
  output logic       fail_valid
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_t           state;
  logic [1:0]       vec;
  logic [CNT_W-1:0] hold_cnt;

  logic             expected_c;
  logic             mismatch;
  logic [2:0]       err_next;
  logic [1:0]       vec_inc;

  // The golden value is computed from the vector register itself, not from
  // A_out/B_out. A fault on the output pins therefore still shows up as a
  // mismatch at C.
  assign expected_c = vec[1] & vec[0];
  assign mismatch   = (C_in != expected_c);

  // One increment per vector at most, so four vectors never overflow 3 bits.
  assign err_next   = err_count + {2'b00, mismatch};
  assign vec_inc    = vec + 2'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      vec        <= 2'd0;
      hold_cnt   <= '0;
      A_out      <= 1'b0;
      B_out      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= 3'd0;
      fail_vec   <= 2'd0;
      fail_valid <= 1'b0;
    end else begin
      case (state)
        // IDLE and DONE share the launch path. Abort has no meaning here,
        // so start wins even when both are high.
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state      <= ST_DRIVE;
            vec        <= 2'd0;
            hold_cnt   <= '0;
            A_out      <= 1'b0;
            B_out      <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= 3'd0;
            fail_vec   <= 2'd0;
            fail_valid <= 1'b0;
          end
        end

        ST_DRIVE: begin
          if (abort) begin
            // Partial err_count and fail_* stay visible until the next start.
            state <= ST_IDLE;
            A_out <= 1'b0;
            B_out <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            pass  <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
            if (hold_cnt == HOLD_LAST) begin
              state <= ST_SAMPLE;
            end
          end
        end

        ST_SAMPLE: begin
          if (abort) begin
            // Abort wins over the pending compare, so this vector is not scored.
            state <= ST_IDLE;
            A_out <= 1'b0;
            B_out <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            pass  <= 1'b0;
          end else begin
            err_count <= err_next;
            if (mismatch && !fail_valid) begin
              fail_vec   <= vec;
              fail_valid <= 1'b1;
            end
            if (vec == 2'd3) begin
              state <= ST_DONE;
              A_out <= 1'b0;
              B_out <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
              // Uses the updated count so that the last vector is included.
              pass  <= (err_next == 3'd0);
            end else begin
              state    <= ST_DRIVE;
              vec      <= vec_inc;
              hold_cnt <= '0;
              A_out    <= vec_inc[1];
              B_out    <= vec_inc[0];
            end
          end
        end

        default: begin
          state <= ST_IDLE;
          A_out <= 1'b0;
          B_out <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
          pass  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/and_gate_test_sequencer.md
Name: and_gate_test_sequencer

Overview:
- Self-test controller for the shared two-input AND gate unit (inputs A/B, output C).
- On a start pulse it drives the four input vectors 00, 01, 10, 11 in order, holds each for a programmable settle time, and samples C.
- It compares each sample against A&B, counts mismatches and reports pass/fail with a start/busy/done handshake.
- It sits beside the gate unit and owns the gate's inputs while a test runs.

Parameters:
- HOLD_CYCLES, 4: cycles each vector is driven before C is sampled; legal range 1..255.
- CNT_W, 8: width of the hold counter; must satisfy 2^CNT_W > HOLD_CYCLES.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a test; honoured only in IDLE or DONE.
- abort  input  1  cancels a running test; returns to IDLE on the next edge.
- C_in  input  1  output C of the AND gate under test.
- A_out  output  1  drives gate input A.
- B_out  output  1  drives gate input B.
- busy  output  1  high in DRIVE and SAMPLE.
- done  output  1  high in DONE; held until the next start or reset.
- pass  output  1  high in DONE when err_count==0; 0 in all other states.
- err_count  output  3  number of mismatching vectors, range 0..4.
- fail_vec  output  2  first vector that mismatched ({A,B}); valid when fail_valid=1.
- fail_valid  output  1  sticky; set on the first mismatch of a run.

Behaviour:
- Reset (async, immediate):
  - State=IDLE, vec=0, hold counter=0.
  - A_out=0, B_out=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, fail_valid=0.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - A_out=B_out=0.
  - start=1 -> DRIVE; vec=0, counter=0, err_count=0, fail_valid=0, fail_vec=0.
- DRIVE:
  - A_out=vec[1], B_out=vec[0].
  - Counter increments each cycle.
  - When counter==HOLD_CYCLES-1 -> SAMPLE. DRIVE therefore lasts exactly HOLD_CYCLES cycles per vector.
- SAMPLE (1 cycle):
  - A_out/B_out still hold vec.
  - Compare C_in against vec[1]&vec[0]. On mismatch, err_count+1. If fail_valid=0, load fail_vec=vec and set fail_valid=1.
  - If vec==3 -> DONE. Otherwise vec+1, counter=0 -> DRIVE.
- DONE:
  - done=1; pass=(err_count==0); A_out=B_out=0.
  - err_count, fail_vec and fail_valid are held.
  - start=1 -> DRIVE with the same clear actions as in IDLE.
- Latency: start sampled at edge 0; done goes high after edge 4*(HOLD_CYCLES+1). Default: 20 cycles.
- start while busy=1: ignored, no restart, no counter effect.
- abort while busy=1:
  - Next state IDLE; done=0, pass=0.
  - err_count and fail_* keep their partial values until the next start.
- abort in IDLE or DONE: no effect.
- start and abort high together while busy: abort wins.
- start and abort high together in IDLE or DONE: start wins.
- err_count cannot exceed 4 (one increment per vector), so no wrap.
- C_in is consumed only in SAMPLE and ignored in all other states.
- Reset asserted mid-run: all outputs return to reset values asynchronously. After release the block waits in IDLE for start.

Test Plan:
- Healthy gate (C_in=A_out&B_out), HOLD_CYCLES=4, start pulse -> busy for 20 cycles; A/B sequence 00,01,10,11 with 4 cycles each; done=1 at edge 20; pass=1, err_count=0, fail_valid=0.
- C_in stuck at 0 -> err_count=1, fail_vec=2'b11, fail_valid=1, pass=0.
- C_in stuck at 1 -> err_count=3, fail_vec=2'b00, pass=0.
- start re-pulsed at cycle 7 of a run -> ignored; done still at edge 20. Then start in DONE -> counts cleared, new 20-cycle run.
- abort at cycle 10 -> IDLE next edge; busy=0, done=0, A_out=B_out=0.
- rst pulsed at cycle 12 -> all outputs 0 immediately, not waiting for a clock edge. start after release -> full run with pass=1 on a healthy gate.
